fifo_param: RTL and testbench

//   Parametrised synchronous FIFO; next-generation successor of the 1-bit, 4-deep shift-queue FIFO.

---
 rtl/fifo_param.sv | 98 +++++++++
 tb/tb_fifo_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous circular-buffer FIFO.
// Registered read port, occupancy level, threshold flags, sticky errors.
module fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2,
    localparam int LW       = $clog2(DEPTH + 1),
    localparam int PW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] I,
    input  logic             pop,
    output logic [WIDTH-1:0] P,
    output logic             P_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [LW-1:0]    level,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop_acc;
    logic             push_acc;
    logic [PW-1:0]    wr_nxt;
    logic [PW-1:0]    rd_nxt;

    // Flags decode straight off the registered level
    assign empty        = (level == '0);
    assign full         = (level == LW'(DEPTH));
    assign almost_full  = (level >= LW'(AF_THRESH));
    assign almost_empty = (level <= LW'(AE_THRESH));

    // A pop frees a slot in the same edge, so a full FIFO may still take a push
    assign pop_acc  = pop & ~empty;
    assign push_acc = push & (~full | pop_acc);

    // Explicit wrap compare keeps non-power-of-two depths correct
    assign wr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    assign rd_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

    // Storage array; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (push_acc && !clear) begin
            mem[wr_ptr] <= I;
        end
    end

    // Pointers, occupancy, read register and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            P         <= '0;
            P_valid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            P         <= '0;
            P_valid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            P_valid <= pop_acc;
            if (pop_acc) begin
                P      <= mem[rd_ptr];
                rd_ptr <= rd_nxt;
            end
            if (push_acc) begin
                wr_ptr <= wr_nxt;
            end
            if (push_acc && !pop_acc) begin
                level <= level + 1'b1;
            end else if (pop_acc && !push_acc) begin
                level <= level - 1'b1;
            end
            if (push && !push_acc) begin
                overflow <= 1'b1;
            end
            if (pop && !pop_acc) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed checks on a 16-deep FIFO plus a
// queue-scoreboarded random run on a 5-deep instance.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear, push, pop;
    logic [7:0] I;
    logic [7:0] P;
    logic       P_valid, full, empty, almost_full, almost_empty;
    logic [4:0] level;
    logic       overflow, underflow;

    logic       d5_clear, d5_push, d5_pop;
    logic [7:0] d5_I;
    logic [7:0] d5_P;
    logic       d5_P_valid, d5_full, d5_empty, d5_af, d5_ae;
    logic [2:0] d5_level;
    logic       d5_ovf, d5_unf;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fifo_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .push(push), .I(I),
        .pop(pop), .P(P), .P_valid(P_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow)
    );

    fifo_param #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) u_d5 (
        .clk(clk), .rst_n(rst_n), .clear(d5_clear), .push(d5_push),
        .I(d5_I), .pop(d5_pop), .P(d5_P), .P_valid(d5_P_valid),
        .full(d5_full), .empty(d5_empty), .almost_full(d5_af),
        .almost_empty(d5_ae), .level(d5_level), .overflow(d5_ovf),
        .underflow(d5_unf)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input logic ps, input logic [7:0] d, input logic pp);
        push = ps;
        I    = d;
        pop  = pp;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input int lv);
        check({tag, ".level"}, level, lv);
        check({tag, ".full"}, full, lv == 16);
        check({tag, ".empty"}, empty, lv == 0);
        check({tag, ".af"}, almost_full, lv >= 12);
        check({tag, ".ae"}, almost_empty, lv <= 2);
    endtask

    logic [7:0] mq[$];
    logic [7:0] m_p;
    logic       m_pv, m_ovf, m_unf;

    initial begin
        rst_n = 1'b0;
        {clear, push, pop} = '0;
        I = '0;
        {d5_clear, d5_push, d5_pop} = '0;
        d5_I = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_flags("rst", 0);
        check("rst.P", P, 0);
        check("rst.pv", P_valid, 0);
        check("rst.ovf", overflow, 0);
        check("rst.unf", underflow, 0);
        rst_n = 1'b1;

        // async reset mid-stream
        for (int i = 0; i < 6; i++) cyc(1, 8'h11 + 8'(i), 0);
        cyc(0, 0, 1);
        check("pre.level", level, 5);
        check("pre.P", P, 8'h11);
        check("pre.pv", P_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.level", level, 0);
        check("arst.empty", empty, 1);
        check("arst.P", P, 0);
        check("arst.pv", P_valid, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // fill / drain
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 8'(i), 0);
            chk_flags($sformatf("fill%0d", i), i);
        end
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 0, 1);
            check($sformatf("drain%0d.P", i), P, i);
            check($sformatf("drain%0d.pv", i), P_valid, 1);
            chk_flags($sformatf("drain%0d", i), 16 - i);
        end
        cyc(0, 0, 0);
        check("idle.pv", P_valid, 0);
        check("idle.P", P, 8'h10);

        // overflow
        for (int i = 0; i < 16; i++) cyc(1, 8'h21 + 8'(i), 0);
        check("ovf.pre", overflow, 0);
        cyc(1, 8'hAA, 0);
        check("ovf.level", level, 16);
        check("ovf.flag", overflow, 1);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 1);
            check($sformatf("ovfd%0d.P", i), P, 8'h21 + 8'(i));
        end
        check("ovf.empty", empty, 1);
        check("ovf.sticky", overflow, 1);

        // underflow with simultaneous push
        cyc(1, 8'h5A, 1);
        check("unf.flag", underflow, 1);
        check("unf.level", level, 1);
        check("unf.P", P, 8'h30);
        check("unf.pv", P_valid, 0);
        cyc(0, 0, 1);
        check("unf.P2", P, 8'h5A);
        check("unf.pv2", P_valid, 1);

        // clear with push pending is ignored
        push = 1'b1;
        I = 8'h99;
        do_clear();
        push = 1'b0;
        chk_flags("clr", 0);
        check("clr.P", P, 0);
        check("clr.ovf", overflow, 0);
        check("clr.unf", underflow, 0);

        // full + push/pop same edge
        for (int i = 0; i < 16; i++) cyc(1, 8'h41 + 8'(i), 0);
        cyc(1, 8'h77, 1);
        check("fpp.level", level, 16);
        check("fpp.P", P, 8'h41);
        check("fpp.ovf", overflow, 0);
        for (int i = 0; i < 15; i++) begin
            cyc(0, 0, 1);
            check($sformatf("fpp%0d.P", i), P, 8'h42 + 8'(i));
        end
        cyc(0, 0, 1);
        check("fpp.last", P, 8'h77);
        check("fpp.empty", empty, 1);

        // random run on the 5-deep instance against a queue model
        mq.delete();
        m_p = 0;
        m_pv = 0;
        m_ovf = 0;
        m_unf = 0;
        for (int c = 0; c < 1000; c++) begin
            logic pp, ps, cl;
            logic [7:0] dd;
            int sz;
            cl = ($urandom_range(0, 39) == 0);
            ps = $urandom_range(0, 1);
            pp = $urandom_range(0, 1);
            dd = 8'($urandom);
            d5_clear = cl;
            d5_push = ps;
            d5_pop = pp;
            d5_I = dd;
            if (cl) begin
                mq.delete();
                m_p = 0;
                m_pv = 0;
                m_ovf = 0;
                m_unf = 0;
            end else begin
                logic pok, wok;
                pok = pp && mq.size() > 0;
                wok = ps && (mq.size() < 5 || pok);
                if (pok) m_p = mq.pop_front();
                m_pv = pok;
                if (wok) mq.push_back(dd);
                if (ps && !wok) m_ovf = 1;
                if (pp && !pok) m_unf = 1;
            end
            @(posedge clk);
            #1;
            sz = mq.size();
            check($sformatf("r%0d.P", c), d5_P, m_p);
            check($sformatf("r%0d.pv", c), d5_P_valid, m_pv);
            check($sformatf("r%0d.lv", c), d5_level, sz);
            check($sformatf("r%0d.full", c), d5_full, sz == 5);
            check($sformatf("r%0d.empty", c), d5_empty, sz == 0);
            check($sformatf("r%0d.af", c), d5_af, sz >= 4);
            check($sformatf("r%0d.ae", c), d5_ae, sz <= 1);
            check($sformatf("r%0d.ovf", c), d5_ovf, m_ovf);
            check($sformatf("r%0d.unf", c), d5_unf, m_unf);
        end
        {d5_clear, d5_push, d5_pop} = '0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
